// File: rtl/servo_pwm_bank.sv
// N-channel servo pulse generator: one shared frame timebase, a per-channel
// arm/drive/gap sequencer and a valid/ready command port with width clamping.
module servo_pwm_bank #(
  parameter int NUM_CH      = 3,
  parameter int CH_W        = 2,
  parameter int FRAME_TICKS = 1000000,
  parameter int FRAME_W     = 20,
  parameter int PULSE_W     = 17,
  parameter int MIN_PULSE   = 50000,
  parameter int MAX_PULSE   = 100000,
  parameter int HOLD_FRAMES = 50,
  parameter int GAP_FRAMES  = 50,
  parameter int FR_CNT_W    = 7
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [CH_W-1:0]    cmd_ch,
  input  logic [PULSE_W-1:0] cmd_width,
  output logic               cmd_err,
  output logic [NUM_CH-1:0]  pwm,
  output logic [NUM_CH-1:0]  busy,
  output logic [NUM_CH-1:0]  done
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARMED,
    ST_DRIVE,
    ST_GAP
  } ch_state_e;

  localparam int CH_SPACE = 1 << CH_W;
  localparam int CMP_W    = (FRAME_W > PULSE_W) ? FRAME_W : PULSE_W;

  localparam logic [FRAME_W-1:0]  FRAME_LAST     = FRAME_W'(FRAME_TICKS - 1);
  localparam logic [FRAME_W-1:0]  FRAME_PRE_LAST = FRAME_W'(FRAME_TICKS - 2);
  localparam logic [PULSE_W-1:0]  MIN_W          = PULSE_W'(MIN_PULSE);
  localparam logic [PULSE_W-1:0]  MAX_W          = PULSE_W'(MAX_PULSE);
  localparam logic [FR_CNT_W-1:0] HOLD_LAST      = FR_CNT_W'(HOLD_FRAMES - 1);
  localparam logic [FR_CNT_W-1:0] GAP_LAST       = FR_CNT_W'(GAP_FRAMES - 1);

  // ---------------------------------------------------------------------------
  // Shared frame timebase
  // ---------------------------------------------------------------------------
  logic [FRAME_W-1:0] frame_cnt_q, frame_cnt_d;
  logic               frame_end;
  logic               frame_pre_end;

  assign frame_end     = (frame_cnt_q == FRAME_LAST);
  assign frame_pre_end = (frame_cnt_q == FRAME_PRE_LAST);

  always_comb begin
    frame_cnt_d = frame_end ? '0 : frame_cnt_q + FRAME_W'(1);
  end

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking (=) here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (rst) frame_cnt_q <= '0;
    else     frame_cnt_q <= frame_cnt_d;
  end

  // ---------------------------------------------------------------------------
  // Command port: decode, handshake, clamp, error flag
  // ---------------------------------------------------------------------------
  logic [NUM_CH-1:0]   ch_idle;
  logic [NUM_CH-1:0]   accept;
  logic [CH_SPACE-1:0] idle_pad;
  logic                ch_valid;
  logic [PULSE_W-1:0]  clamped_width;
  logic                cmd_err_q, cmd_err_d;

  assign ch_valid = (int'(cmd_ch) < NUM_CH);

  // Unpopulated channel slots read as idle so an invalid command is accepted
  // (and dropped) instead of stalling the decoder forever.
  always_comb begin
    idle_pad              = '1;
    idle_pad[NUM_CH-1:0]  = ch_idle;
  end

  assign cmd_ready = idle_pad[cmd_ch];

  always_comb begin
    // NOTE: every path assigns clamped_width, so no latch is inferred; an
    // if without a final else in always_comb would infer one.
    if (cmd_width < MIN_W)      clamped_width = MIN_W;
    else if (cmd_width > MAX_W) clamped_width = MAX_W;
    else                        clamped_width = cmd_width;
  end

  assign cmd_err_d = cmd_valid && !ch_valid;

  always_ff @(posedge clk) begin
    if (rst) cmd_err_q <= 1'b0;
    else     cmd_err_q <= cmd_err_d;
  end

  assign cmd_err = cmd_err_q;

  // ---------------------------------------------------------------------------
  // Per-channel sequencers
  // ---------------------------------------------------------------------------
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    ch_state_e           state_q, state_d;
    logic [FR_CNT_W-1:0] frames_q, frames_d;
    logic [PULSE_W-1:0]  width_q, width_d;
    logic                pwm_q, pwm_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                last_hold;
    logic                last_gap;

    assign ch_idle[i] = (state_q == ST_IDLE);
    assign accept[i]  = cmd_valid && (cmd_ch == CH_W'(i)) && ch_idle[i];
    assign last_hold  = (frames_q == HOLD_LAST);
    assign last_gap   = (frames_q == GAP_LAST);

    // State register, including the registered outputs.
    always_ff @(posedge clk) begin
      if (rst) begin
        state_q  <= ST_IDLE;
        frames_q <= '0;
        // NOTE: the stored width is a per-channel register, not a RAM, so it
        // is cleared on reset like the rest of the state.
        width_q  <= '0;
        pwm_q    <= 1'b0;
        busy_q   <= 1'b0;
        done_q   <= 1'b0;
      end else begin
        state_q  <= state_d;
        frames_q <= frames_d;
        width_q  <= width_d;
        pwm_q    <= pwm_d;
        busy_q   <= busy_d;
        done_q   <= done_d;
      end
    end

    // Next-state logic.
    always_comb begin
      state_d  = state_q;
      frames_d = frames_q;
      width_d  = width_q;
      unique case (state_q)
        ST_IDLE: begin
          if (accept[i]) begin
            width_d  = clamped_width;
            frames_d = '0;
            // Accepting on the last tick of a frame starts driving at once.
            state_d  = frame_end ? ST_DRIVE : ST_ARMED;
          end
        end
        ST_ARMED: begin
          if (frame_end) begin
            state_d  = ST_DRIVE;
            frames_d = '0;
          end
        end
        ST_DRIVE: begin
          if (frame_end) begin
            if (last_hold) begin
              frames_d = '0;
              state_d  = (GAP_FRAMES == 0) ? ST_IDLE : ST_GAP;
            end else begin
              frames_d = frames_q + FR_CNT_W'(1);
            end
          end
        end
        ST_GAP: begin
          if (frame_end) begin
            if (last_gap) begin
              frames_d = '0;
              state_d  = ST_IDLE;
            end else begin
              frames_d = frames_q + FR_CNT_W'(1);
            end
          end
        end
        default: begin
          state_d  = ST_IDLE;
          frames_d = '0;
        end
      endcase
    end

    // Output logic. done is looked ahead by one tick so the registered pulse
    // lands on the final cycle of the sequence, while busy is still high.
    always_comb begin
      pwm_d  = (state_q == ST_DRIVE) && (CMP_W'(frame_cnt_q) < CMP_W'(width_q));
      busy_d = (state_d != ST_IDLE);
      done_d = frame_pre_end &&
               (((state_q == ST_GAP) && last_gap) ||
                ((GAP_FRAMES == 0) && (state_q == ST_DRIVE) && last_hold));
    end

    assign pwm[i]  = pwm_q;
    assign busy[i] = busy_q;
    assign done[i] = done_q;
  end

endmodule

// File: tb/tb_servo_pwm_bank.sv
// Directed bench for servo_pwm_bank with a short frame (20 ticks), 3 hold
// frames, 2 gap frames; a negedge monitor counts pwm-high cycles and pulses.
module tb_servo_pwm_bank;

  localparam int NUM_CH      = 3;
  localparam int CH_W        = 2;
  localparam int FRAME_TICKS = 20;
  localparam int FRAME_W     = 5;
  localparam int PULSE_W     = 7;
  localparam int MIN_PULSE   = 2;
  localparam int MAX_PULSE   = 10;
  localparam int HOLD_FRAMES = 3;
  localparam int GAP_FRAMES  = 2;
  localparam int FR_CNT_W    = 2;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               cmd_valid = 1'b0;
  logic [CH_W-1:0]    cmd_ch = '0;
  logic [PULSE_W-1:0] cmd_width = '0;
  logic               cmd_ready;
  logic               cmd_err;
  logic [NUM_CH-1:0]  pwm;
  logic [NUM_CH-1:0]  busy;
  logic [NUM_CH-1:0]  done;

  int n_checks = 0;
  int n_errors = 0;
  int n = 0;              // cycle index since the last reset release
  int pwm_hi [NUM_CH];
  int done_cnt [NUM_CH];
  int err_cnt = 0;
  logic ever_busy = 1'b0;

  always #5 clk = ~clk;

  servo_pwm_bank #(
    .NUM_CH      (NUM_CH),
    .CH_W        (CH_W),
    .FRAME_TICKS (FRAME_TICKS),
    .FRAME_W     (FRAME_W),
    .PULSE_W     (PULSE_W),
    .MIN_PULSE   (MIN_PULSE),
    .MAX_PULSE   (MAX_PULSE),
    .HOLD_FRAMES (HOLD_FRAMES),
    .GAP_FRAMES  (GAP_FRAMES),
    .FR_CNT_W    (FR_CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_ch    (cmd_ch),
    .cmd_width (cmd_width),
    .cmd_err   (cmd_err),
    .pwm       (pwm),
    .busy      (busy),
    .done      (done)
  );

  always @(negedge clk) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (pwm[i])  pwm_hi[i]++;
      if (done[i]) done_cnt[i]++;
    end
    if (cmd_err) err_cnt++;
    if (busy != '0) ever_busy = 1'b1;
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    n++;
  endtask

  task automatic wait_until(input int target);
    while (n < target) tick();
  endtask

  task automatic clear_counts();
    for (int i = 0; i < NUM_CH; i++) begin
      pwm_hi[i]   = 0;
      done_cnt[i] = 0;
    end
    err_cnt   = 0;
    ever_busy = 1'b0;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    cmd_valid = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    n   = 0;
    clear_counts();
  endtask

  task automatic send(input int ch, input int width);
    cmd_valid = 1'b1;
    cmd_ch    = CH_W'(ch);
    cmd_width = PULSE_W'(width);
    #1;
  endtask

  task automatic idle_cmd();
    cmd_valid = 1'b0;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // Reset, then 100 idle cycles
    do_reset();
    cmd_ch = 2'd0;
    #1;
    check("rst_pwm", int'(pwm), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_err", int'(cmd_err), 0);
    check("rst_ready", int'(cmd_ready), 1);
    wait_until(100);
    check("idle_pwm_cnt", pwm_hi[0] + pwm_hi[1] + pwm_hi[2], 0);
    check("idle_done_cnt", done_cnt[0] + done_cnt[1] + done_cnt[2], 0);
    check("idle_err_cnt", err_cnt, 0);
    check("idle_busy_seen", int'(ever_busy), 0);
    cmd_ch = 2'd2;
    #1;
    check("idle_ready_ch2", int'(cmd_ready), 1);

    // ch0 width 5 accepted at frame_cnt 7: drive frames 1..3, gap 4..5
    do_reset();
    wait_until(7);
    send(0, 5);
    check("b_ready", int'(cmd_ready), 1);
    check("b_busy_pre", int'(busy), 0);
    tick();
    idle_cmd();
    check("b_busy_next", int'(busy), 1);
    wait_until(20);
    check("b_pwm_fc0", int'(pwm), 0);
    wait_until(21);
    check("b_pwm_first", int'(pwm), 1);
    wait_until(25);
    check("b_pwm_fifth", int'(pwm), 1);
    wait_until(26);
    check("b_pwm_sixth", int'(pwm), 0);
    wait_until(118);
    check("b_done_early", int'(done), 0);
    wait_until(119);
    check("b_done", int'(done), 1);
    check("b_busy_at_done", int'(busy), 1);
    check("b_pwm_total", pwm_hi[0], 15);
    wait_until(120);
    cmd_ch = 2'd0;
    #1;
    check("b_done_after", int'(done), 0);
    check("b_busy_after", int'(busy), 0);
    check("b_done_cnt", done_cnt[0], 1);
    check("b_ready_after", int'(cmd_ready), 1);

    // Clamp: ch1 width 1 -> 2, ch2 width 50 -> 10
    do_reset();
    wait_until(3);
    send(1, 1);
    tick();
    send(2, 50);
    check("c_ready_ch2", int'(cmd_ready), 1);
    tick();
    idle_cmd();
    check("c_busy", int'(busy), 6);
    wait_until(21);
    check("c_pwm_21", int'(pwm), 6);
    wait_until(23);
    check("c_pwm_23", int'(pwm), 4);
    wait_until(30);
    check("c_pwm_30", int'(pwm), 4);
    wait_until(31);
    check("c_pwm_31", int'(pwm), 0);
    wait_until(100);
    check("c_ch1_total", pwm_hi[1], 6);
    check("c_ch2_total", pwm_hi[2], 30);
    wait_until(119);
    check("c_done_both", int'(done), 6);

    // Stall on busy ch0 while ch1 is accepted
    do_reset();
    wait_until(2);
    send(0, 3);
    tick();
    send(1, 4);
    check("d_ready_ch1", int'(cmd_ready), 1);
    tick();
    send(0, 7);
    check("d_ready_busy", int'(cmd_ready), 0);
    wait_until(50);
    check("d_ready_mid", int'(cmd_ready), 0);
    wait_until(119);
    check("d_ready_at_done", int'(cmd_ready), 0);
    check("d_done", int'(done), 3);
    wait_until(120);
    check("d_ready_released", int'(cmd_ready), 1);
    check("d_busy_120", int'(busy), 0);
    tick();
    idle_cmd();
    check("d_busy_rearm", int'(busy), 1);
    wait_until(200);
    check("d_ch0_total", pwm_hi[0], 30);
    check("d_ch1_total", pwm_hi[1], 12);
    wait_until(239);
    check("d_done2", int'(done), 1);
    wait_until(240);
    check("d_done_cnt", done_cnt[0], 2);
    check("d_busy_end", int'(busy), 0);

    // Invalid channel, then an accept on the frame_end cycle
    do_reset();
    wait_until(5);
    send(3, 5);
    check("e_ready_inv", int'(cmd_ready), 1);
    tick();
    idle_cmd();
    check("e_err", int'(cmd_err), 1);
    check("e_busy", int'(busy), 0);
    tick();
    check("e_err_off", int'(cmd_err), 0);
    wait_until(19);
    send(2, 4);
    check("e_ready_fe", int'(cmd_ready), 1);
    tick();
    idle_cmd();
    check("e_busy_fe", int'(busy), 4);
    wait_until(21);
    check("e_pwm_21", int'(pwm), 4);
    wait_until(24);
    check("e_pwm_24", int'(pwm), 4);
    wait_until(25);
    check("e_pwm_25", int'(pwm), 0);
    check("e_err_cnt", err_cnt, 1);

    // Reset in the middle of DRIVE on ch0
    do_reset();
    wait_until(3);
    send(0, 8);
    tick();
    idle_cmd();
    wait_until(23);
    check("f_pwm_pre", int'(pwm), 1);
    check("f_busy_pre", int'(busy), 1);
    rst = 1'b1;
    tick();
    check("f_pwm_rst", int'(pwm), 0);
    check("f_busy_rst", int'(busy), 0);
    check("f_done_rst", int'(done), 0);
    rst = 1'b0;
    n   = 0;
    clear_counts();
    send(1, 2);
    check("f_ready", int'(cmd_ready), 1);
    tick();
    idle_cmd();
    wait_until(20);
    check("f_pwm_20", int'(pwm), 0);
    wait_until(21);
    check("f_pwm_21", int'(pwm), 2);
    wait_until(23);
    check("f_pwm_23", int'(pwm), 0);
    wait_until(130);
    check("f_ch0_total", pwm_hi[0], 0);
    check("f_ch0_done", done_cnt[0], 0);
    check("f_ch1_done", done_cnt[1], 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
